// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
// The optional overflow output is controlled by SERIAL_ADD_OVF_EN (see serial_add_if / serial_add_ctrl).
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_if.sv
// Request/result bundle for serial_add_ctrl; the requester drives master, the adder implements slave.
// With SERIAL_ADD_OVF_EN defined the bundle also carries the signed-overflow flag ovf.
interface serial_add_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_add_full_adder.sv
// One-bit combinational full adder used as the time-multiplexed slice of serial_add_ctrl.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin over WIDTH cycles, LSB first, through one full_adder.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_add_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-2:0]   res_sh_q, res_sh_d;
  logic [WIDTH-1:0]   res_next;
  logic               fa_s, fa_co;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  full_adder u_slice (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Result bits enter at the MSB end; after WIDTH shifts bit 0 of a+b sits at sum[0].
  assign res_next = {fa_s, res_sh_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    cout_d   = cout_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next[WIDTH-1:1];
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Shadow result is published only here, so sum/cout never show partial bits.
          state_d = DONE;
          done_d  = 1'b1;
          sum_d   = res_next;
          cout_d  = fa_co;
          cnt_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Operand and partial-result shifters are always reloaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    a_sh_q   <= a_sh_d;
    b_sh_q   <= b_sh_d;
    res_sh_q <= res_sh_d;
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: the driver queues hand-computed results, a negedge monitor checks them.
module tb_serial_add_ctrl;

  localparam int W = 20;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  logic [W-1:0] held_sum = '0;
  logic         held_cout = 1'b0;
  exp_t sb[$];

  serial_add_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("sum", 64'(bus.sum), 64'(e.sum));
          chk("cout", 64'(bus.cout), 64'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
          chk("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
          chk("done_latency", 64'(cyc - e.acc), 64'(W + 1));
          chk("busy_with_done", 64'(bus.busy), 64'd1);
          held_sum  = bus.sum;
          held_cout = bus.cout;
        end
      end else if (bus.busy) begin
        chk("hold_sum", 64'(bus.sum), 64'(held_sum));
        chk("hold_cout", 64'(bus.cout), 64'(held_cout));
      end
    end
  end

  task automatic push(input logic [W-1:0] s, input logic co, input logic ov);
    exp_t e;
    e.sum = s; e.cout = co; e.ovf = ov; e.acc = cyc;
    sb.push_back(e);
  endtask

  // Drive start in the current cycle (caller is at a negedge) and drop it one cycle later.
  task automatic drive_now(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                           input logic [W-1:0] s, input logic co, input logic ov);
    bus.start = 1'b1; bus.a = va; bus.b = vb; bus.cin = vc;
    push(s, co, ov);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
  endtask

  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       input logic [W-1:0] s, input logic co, input logic ov);
    @(negedge clk);
    drive_now(va, vb, vc, s, co, ov);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int c0;
    int n;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 0 + FFFFF, then back-to-back 1 + 1 in the IDLE cycle after DONE
    issue(20'h00000, 20'hFFFFF, 1'b0, 20'hFFFFF, 1'b0, 1'b0);
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL b2b_wait actual=no_done required=done");
    end
    @(negedge clk);
    chk("b2b_idle_busy", 64'(bus.busy), 64'd0);
    drive_now(20'h00001, 20'h00001, 1'b0, 20'h00002, 1'b0, 1'b0);
    wait_idle();

    // Full carry ripple
    issue(20'hFFFFF, 20'h00000, 1'b1, 20'h00000, 1'b1, 1'b0);
    wait_idle();

    // start held through RUN with a changed: only the first operands count until IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.a = 20'h12345; bus.b = 20'h0ABCD; bus.cin = 1'b0;
    c0 = cyc;
    push(20'h1CF12, 1'b0, 1'b0);
    @(negedge clk);
    bus.a = 20'hFFFFF;
    n = 0;
    while (cyc != c0 + W + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    push(20'h0ABCC, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Reset in RUN cycle 10: abort, no done, outputs cleared
    issue(20'h55555, 20'h33333, 1'b0, 20'h88888, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    held_sum = '0;
    held_cout = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_sum", 64'(bus.sum), 64'd0);
    chk("abort_cout", 64'(bus.cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_now(20'h12345, 20'h11111, 1'b0, 20'h23456, 1'b0, 1'b0);
    wait_idle();

`ifdef SERIAL_ADD_OVF_EN
    issue(20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b0, 1'b1);
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
